// File: rtl/nmc_mc.sv
// rtl/nmc_mc.sv - multi-channel near-memory-compute unit with shared entry store and tagged response port
// Write/query FIFOs feed a round-robin issue stage, then a stage-1 register and a compute/output register.

module nmc_mc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic [AW:0]   w_cnt_nxt;

  // A push against a full FIFO is dropped even if a pop frees a slot on the same edge.
  assign w_push_ok = i_push && !r_full;
  assign w_pop_ok  = i_pop && (r_cnt != '0);
  assign w_cnt_nxt = r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd   <= '0;
      r_wr   <= '0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_data;
  end

  assign o_data  = r_mem[r_rd];
  assign o_empty = (r_cnt == '0);
  assign o_full  = r_full;
endmodule

module nmc_mc #(
  parameter int N_CH            = 2,
  parameter int ADDR_W          = 8,
  parameter int ENTRY_W         = 32,
  parameter int ID_W            = 4,
  parameter int NWR_FIFO_DEPTH  = 4,
  parameter int NQR_FIFO_DEPTH  = 4,
  parameter int NMC_COUNT_THRES = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    nwr_push,
  input  logic [ADDR_W-1:0]       nwr_addr,
  input  logic [ENTRY_W-1:0]      nwr_entry,
  output logic                    nwr_full,
  input  logic [N_CH-1:0]         nqr_push,
  input  logic [N_CH*ADDR_W-1:0]  nqr_addr,
  input  logic [N_CH*ENTRY_W-1:0] nqr_feature,
  input  logic [N_CH-1:0]         nqr_mode,
  input  logic [N_CH*ID_W-1:0]    nqr_id,
  output logic [N_CH-1:0]         nqr_full,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [CH_W-1:0]         resp_ch,
  output logic [ID_W-1:0]         resp_id,
  output logic                    resp_found,
  output logic [ENTRY_W-1:0]      resp_result
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int D_W   = $clog2(ENTRY_W+1);
  localparam int QW    = 1 + ID_W + ADDR_W + ENTRY_W;
  localparam int WW    = ADDR_W + ENTRY_W;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]   r_vld;
  logic [CH_W-1:0]    r_rr;

  logic               w_adv;
  logic [WW-1:0]      w_wr_data;
  logic               w_wr_empty;
  logic               w_wr_pop;
  logic [ADDR_W-1:0]  w_wr_addr;
  logic [ENTRY_W-1:0] w_wr_entry;

  logic [QW-1:0]      w_q_data [N_CH];
  logic [N_CH-1:0]    w_q_empty;
  logic [N_CH-1:0]    w_q_pop;
  logic               w_gnt_vld;
  logic [CH_W-1:0]    w_gnt;
  logic [CH_W:0]      w_sum;
  logic [QW-1:0]      w_sel;
  logic               w_sel_mode;
  logic [ID_W-1:0]    w_sel_id;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [ENTRY_W-1:0] w_sel_feat;
  logic               w_bypass;
  logic [ENTRY_W-1:0] w_rd_entry;
  logic               w_rd_vld;

  logic               r_s0_occ, r_s0_vld, r_s0_mode;
  logic [ENTRY_W-1:0] r_s0_entry, r_s0_feat;
  logic [ID_W-1:0]    r_s0_id;
  logic [CH_W-1:0]    r_s0_ch;
  logic               r_s1_occ, r_s1_vld, r_s1_mode;
  logic [ENTRY_W-1:0] r_s1_entry, r_s1_feat;
  logic [ID_W-1:0]    r_s1_id;
  logic [CH_W-1:0]    r_s1_ch;

  logic [ENTRY_W-1:0] w_xor;
  logic [D_W-1:0]     w_dist;
  logic               w_found;
  logic [ENTRY_W-1:0] w_result;

  assign w_adv = !resp_valid || resp_ready;

  nmc_mc_fifo #(.W(WW), .DEPTH(NWR_FIFO_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (nwr_push),
    .i_data  ({nwr_addr, nwr_entry}),
    .i_pop   (w_wr_pop),
    .o_data  (w_wr_data),
    .o_empty (w_wr_empty),
    .o_full  (nwr_full)
  );

  assign w_wr_pop = !w_wr_empty;
  assign {w_wr_addr, w_wr_entry} = w_wr_data;

  for (genvar c = 0; c < N_CH; c++) begin : g_q
    assign w_q_pop[c] = w_adv && w_gnt_vld && (w_gnt == CH_W'(c));
    nmc_mc_fifo #(.W(QW), .DEPTH(NQR_FIFO_DEPTH)) u_q_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (nqr_push[c]),
      .i_data  ({nqr_mode[c], nqr_id[c*ID_W +: ID_W], nqr_addr[c*ADDR_W +: ADDR_W],
                 nqr_feature[c*ENTRY_W +: ENTRY_W]}),
      .i_pop   (w_q_pop[c]),
      .o_data  (w_q_data[c]),
      .o_empty (w_q_empty[c]),
      .o_full  (nqr_full[c])
    );
  end

  // Scan downwards so the channel closest to r_rr (offset 0) wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_sum     = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr} + (CH_W+1)'(i);
      if (w_sum >= (CH_W+1)'(N_CH)) w_sum = w_sum - (CH_W+1)'(N_CH);
      if (!w_q_empty[w_sum[CH_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_sum[CH_W-1:0];
      end
    end
  end

  assign w_sel = w_q_data[w_gnt];
  assign {w_sel_mode, w_sel_id, w_sel_addr, w_sel_feat} = w_sel;

  // A write committing on the issue edge is forwarded so the query sees it.
  assign w_bypass   = w_wr_pop && (w_wr_addr == w_sel_addr);
  assign w_rd_entry = w_bypass ? w_wr_entry : r_mem[w_sel_addr];
  assign w_rd_vld   = w_bypass || r_vld[w_sel_addr];

  always_ff @(posedge clk) begin
    if (w_wr_pop) r_mem[w_wr_addr] <= w_wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (w_wr_pop) begin
      r_vld[w_wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr       <= '0;
      r_s0_occ   <= 1'b0;
      r_s0_vld   <= 1'b0;
      r_s0_mode  <= 1'b0;
      r_s0_entry <= '0;
      r_s0_feat  <= '0;
      r_s0_id    <= '0;
      r_s0_ch    <= '0;
      r_s1_occ   <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_entry <= '0;
      r_s1_feat  <= '0;
      r_s1_id    <= '0;
      r_s1_ch    <= '0;
    end else if (w_adv) begin
      if (w_gnt_vld) r_rr <= (w_gnt == CH_W'(N_CH-1)) ? '0 : w_gnt + CH_W'(1);
      r_s0_occ   <= w_gnt_vld;
      r_s0_vld   <= w_rd_vld;
      r_s0_mode  <= w_sel_mode;
      r_s0_entry <= w_rd_entry;
      r_s0_feat  <= w_sel_feat;
      r_s0_id    <= w_sel_id;
      r_s0_ch    <= w_gnt;
      r_s1_occ   <= r_s0_occ;
      r_s1_vld   <= r_s0_vld;
      r_s1_mode  <= r_s0_mode;
      r_s1_entry <= r_s0_entry;
      r_s1_feat  <= r_s0_feat;
      r_s1_id    <= r_s0_id;
      r_s1_ch    <= r_s0_ch;
    end
  end

  assign w_xor = r_s1_entry ^ r_s1_feat;

  always_comb begin
    w_dist   = '0;
    w_found  = 1'b0;
    w_result = '0;
    for (int b = 0; b < ENTRY_W; b++) w_dist = w_dist + D_W'(w_xor[b]);
    if (r_s1_vld) begin
      if (!r_s1_mode) begin
        w_found  = (r_s1_entry == r_s1_feat);
        w_result = r_s1_entry;
      end else begin
        w_found  = (w_dist <= D_W'(NMC_COUNT_THRES));
        w_result = ENTRY_W'(w_dist);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid  <= 1'b0;
      resp_ch     <= '0;
      resp_id     <= '0;
      resp_found  <= 1'b0;
      resp_result <= '0;
    end else if (w_adv) begin
      resp_valid <= r_s1_occ;
      if (r_s1_occ) begin
        resp_ch     <= r_s1_ch;
        resp_id     <= r_s1_id;
        resp_found  <= w_found;
        resp_result <= w_result;
      end
    end
  end
endmodule

// File: tb/tb_nmc_mc.sv
// tb/tb_nmc_mc.sv - self-checking bench for nmc_mc against a queue-level model
// Model tracks FIFOs as queues and a three-slot in-flight line; results computed at issue.

module tb_nmc_mc;
  localparam int NWR = 4;
  localparam int NQR = 4;
  localparam int THRES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nwr_push = 1'b0;
  logic [7:0]  nwr_addr = '0;
  logic [31:0] nwr_entry = '0;
  logic        nwr_full;
  logic [1:0]  nqr_push = '0;
  logic [15:0] nqr_addr = '0;
  logic [63:0] nqr_feature = '0;
  logic [1:0]  nqr_mode = '0;
  logic [7:0]  nqr_id = '0;
  logic [1:0]  nqr_full;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_ch;
  logic [3:0]  resp_id;
  logic        resp_found;
  logic [31:0] resp_result;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nmc_mc #(
    .N_CH(2), .ADDR_W(8), .ENTRY_W(32), .ID_W(4),
    .NWR_FIFO_DEPTH(NWR), .NQR_FIFO_DEPTH(NQR), .NMC_COUNT_THRES(THRES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .nwr_push(nwr_push), .nwr_addr(nwr_addr), .nwr_entry(nwr_entry), .nwr_full(nwr_full),
    .nqr_push(nqr_push), .nqr_addr(nqr_addr), .nqr_feature(nqr_feature), .nqr_mode(nqr_mode),
    .nqr_id(nqr_id), .nqr_full(nqr_full),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_ch(resp_ch), .resp_id(resp_id),
    .resp_found(resp_found), .resp_result(resp_result)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { bit v; int ch; int id; bit found; logic [31:0] result; } rsp_t;
  typedef struct { int a; logic [31:0] d; } wr_t;
  typedef struct { int a; logic [31:0] f; bit mode; int id; } q_t;

  logic [31:0] m_mem [256];
  bit          m_vld [256];
  wr_t         m_wq [$];
  q_t          m_qq [2][$];
  rsp_t        m_s0, m_s1, m_out, m_new;
  int          m_rr;
  bit          m_init = 1'b0;
  int          m_wsz;
  int          m_qsz [2];
  bit          m_adv, m_got;
  int          m_c, m_d;
  wr_t         m_w;
  q_t          m_q;

  always @(posedge clk) begin
    if (!rst_n) begin
      foreach (m_vld[i]) m_vld[i] = 1'b0;
      m_wq.delete();
      m_qq[0].delete();
      m_qq[1].delete();
      m_s0.v = 1'b0; m_s1.v = 1'b0; m_out.v = 1'b0;
      m_rr = 0;
      m_init = 1'b1;
    end else begin
      m_wsz = m_wq.size();
      m_qsz[0] = m_qq[0].size();
      m_qsz[1] = m_qq[1].size();
      m_adv = !m_out.v || resp_ready;
      if (m_wsz > 0) begin
        m_w = m_wq.pop_front();
        m_mem[m_w.a] = m_w.d;
        m_vld[m_w.a] = 1'b1;
      end
      if (m_adv) begin
        m_new.v = 1'b0; m_new.ch = 0; m_new.id = 0; m_new.found = 1'b0; m_new.result = '0;
        m_got = 1'b0;
        for (int i = 0; i < 2; i++) begin
          m_c = (m_rr + i) % 2;
          if (!m_got && m_qq[m_c].size() > 0) begin
            m_got = 1'b1;
            m_q = m_qq[m_c].pop_front();
            m_new.v = 1'b1; m_new.ch = m_c; m_new.id = m_q.id;
            if (!m_vld[m_q.a]) begin
              m_new.found = 1'b0; m_new.result = '0;
            end else if (!m_q.mode) begin
              m_new.found = (m_mem[m_q.a] == m_q.f); m_new.result = m_mem[m_q.a];
            end else begin
              m_d = $countones(m_mem[m_q.a] ^ m_q.f);
              m_new.found = (m_d <= THRES); m_new.result = 32'(m_d);
            end
            m_rr = (m_c + 1) % 2;
          end
        end
        m_out = m_s1; m_s1 = m_s0; m_s0 = m_new;
      end
      if (nwr_push && m_wsz < NWR) m_wq.push_back('{a: int'(nwr_addr), d: nwr_entry});
      for (int c = 0; c < 2; c++)
        if (nqr_push[c] && m_qsz[c] < NQR)
          m_qq[c].push_back('{a: int'(nqr_addr[c*8 +: 8]), f: nqr_feature[c*32 +: 32],
                              mode: nqr_mode[c], id: int'(nqr_id[c*4 +: 4])});
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      check("resp_valid", resp_valid, m_out.v);
      check("nwr_full", nwr_full, m_wq.size() == NWR);
      check("nqr_full", nqr_full, {m_qq[1].size() == NQR, m_qq[0].size() == NQR});
      if (m_out.v) begin
        check("resp_ch", resp_ch, m_out.ch);
        check("resp_id", resp_id, m_out.id);
        check("resp_found", resp_found, m_out.found);
        check("resp_result", resp_result, m_out.result);
      end
    end
  end

  task automatic clr();
    nwr_push = 1'b0;
    nqr_push = '0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    nwr_push = 1'b1; nwr_addr = a; nwr_entry = d;
  endtask

  task automatic qr(input int c, input logic [7:0] a, input logic [31:0] f, input logic m,
                    input logic [3:0] id);
    nqr_push[c] = 1'b1;
    nqr_addr[c*8 +: 8] = a;
    nqr_feature[c*32 +: 32] = f;
    nqr_mode[c] = m;
    nqr_id[c*4 +: 4] = id;
  endtask

  task automatic step();
    @(negedge clk);
    clr();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_resp(input int ch, input int id, input bit found, input logic [31:0] res);
    int n;
    n = 0;
    while (!resp_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no response expected id %0d", id);
    end else begin
      check("lit_ch", resp_ch, ch);
      check("lit_id", resp_id, id);
      check("lit_found", resp_found, found);
      check("lit_result", resp_result, res);
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    resp_ready = 1'b1;
    idle(3);
    check("rst_valid", resp_valid, 0);
    check("rst_wfull", nwr_full, 0);
    check("rst_qfull", nqr_full, 0);
    check("rst_ch", resp_ch, 0);
    check("rst_id", resp_id, 0);
    check("rst_found", resp_found, 0);
    check("rst_result", resp_result, 0);
    rst_n = 1'b1;
    idle(1);

    // exact match with latency
    wr(8'h05, 32'hDEADBEEF); step();
    idle(1);
    qr(0, 8'h05, 32'hDEADBEEF, 1'b0, 4'd3); step();
    lat = 0;
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    check("t1_ch", resp_ch, 0);
    check("t1_id", resp_id, 3);
    check("t1_found", resp_found, 1);
    check("t1_result", resp_result, 32'hDEADBEEF);
    @(negedge clk);

    // Hamming mode and unwritten address
    wr(8'h07, 32'h0000000F); step();
    qr(0, 8'h07, 32'h00000000, 1'b1, 4'd1); step();
    qr(0, 8'h07, 32'hFFFFFFF0, 1'b1, 4'd2); step();
    qr(0, 8'h10, 32'h00000000, 1'b1, 4'd3); step();
    expect_resp(0, 1, 1'b1, 32'd4);
    expect_resp(0, 2, 1'b0, 32'd32);
    expect_resp(0, 3, 1'b0, 32'd0);

    // same-edge write/query bypass
    wr(8'h22, 32'h1);
    qr(1, 8'h22, 32'h1, 1'b0, 4'd6); step();
    expect_resp(1, 6, 1'b1, 32'h1);
    idle(2);

    // backpressure, full flags, drop, alternation
    resp_ready = 1'b0;
    qr(1, 8'h05, 32'hDEADBEEF, 1'b0, 4'd5); step();
    qr(1, 8'h05, 32'hDEADBEEF, 1'b0, 4'd6); step();
    qr(1, 8'h05, 32'hDEADBEEF, 1'b0, 4'd7); step();
    idle(3);
    for (int k = 0; k < 4; k++) begin
      qr(0, 8'h05, 32'hDEADBEEF, 1'b0, 4'(1 + k));
      qr(1, 8'h05, 32'hDEADBEEF, 1'b0, 4'(9 + k));
      step();
    end
    check("full_after4", nqr_full, 2'b11);
    qr(0, 8'h05, 32'hDEADBEEF, 1'b0, 4'd15);
    qr(1, 8'h05, 32'hDEADBEEF, 1'b0, 4'd15);
    step();
    check("full_after5", nqr_full, 2'b11);
    idle(2);
    check("stall_valid", resp_valid, 1);
    check("stall_ch", resp_ch, 1);
    check("stall_id", resp_id, 5);
    resp_ready = 1'b1;
    expect_resp(1, 5, 1'b1, 32'hDEADBEEF);
    expect_resp(1, 6, 1'b1, 32'hDEADBEEF);
    expect_resp(1, 7, 1'b1, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      expect_resp(0, 1 + k, 1'b1, 32'hDEADBEEF);
      expect_resp(1, 9 + k, 1'b1, 32'hDEADBEEF);
    end
    idle(5);
    check("drained", resp_valid, 0);
    check("drained_full", nqr_full, 2'b00);

    // reset with queries in flight
    wr(8'h30, 32'h0000ABCD); step();
    idle(2);
    qr(0, 8'h30, 32'h0000ABCD, 1'b0, 4'd1); step();
    qr(0, 8'h30, 32'h0000ABCD, 1'b0, 4'd2); step();
    qr(0, 8'h30, 32'h0000ABCD, 1'b0, 4'd3); step();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_valid", resp_valid, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_flush", resp_valid, 0);
    end
    qr(0, 8'h30, 32'h0000ABCD, 1'b0, 4'd4); step();
    expect_resp(0, 4, 1'b0, 32'h0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
